// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ImmSrc format encoding, opcode constants and
// the immediate range rule used by the instruction encoder.
package riscv_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_U = 2'b11
  } imm_src_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_FINISH = 2'b10
  } load_state_e;

  // True when the sign-extended immediate survives encode-then-extend unchanged.
  function automatic logic imm_in_range(input imm_src_e fmt, input logic [31:0] imm);
    logic ok;
    case (fmt)
      IMM_I, IMM_S: ok = (&imm[31:11]) || !(|imm[31:11]);
      IMM_B:        ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
      IMM_U:        ok = !(|imm[11:0]);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_encode.sv
// Combinational packer: scatters the immediate into its I/S/B/U bit slots
// and flags immediates that cannot be represented in the chosen format.
module imm_encode
  import riscv_pkg::*;
(
  input  imm_src_e    fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        range_err
);

  always_comb begin
    instr = '0;
    case (fmt)
      IMM_I:   instr = {imm[11:0], rs1, funct3, rd, opcode};
      IMM_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      IMM_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      IMM_U:   instr = {imm[31:12], rd, opcode};
      default: instr = '0;
    endcase
  end

  assign range_err = !imm_in_range(fmt, imm);

endmodule

// File: rtl/instr_encoder.sv
// Boot/test program loader: encodes decoded fields into RV32I words and
// streams them into instruction memory through a registered write port.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int BASE_ADDR   = 0,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam int                CNT_W    = $clog2(DEPTH_WORDS + 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH_WORDS - 1);

  load_state_e       state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [CNT_W-1:0]  word_cnt;
  logic [31:0]       instr;
  logic              range_err;
  logic              accept;
  logic              depth_hit;
  logic              unused_funct7;

  // funct7 only matters for R-type, which this loader does not emit.
  assign unused_funct7 = ^in_funct7;

  imm_encode u_imm_encode (
    .fmt       (imm_src_e'(in_fmt)),
    .opcode    (in_opcode),
    .rd        (in_rd),
    .funct3    (in_funct3),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .imm       (in_imm),
    .instr     (instr),
    .range_err (range_err)
  );

  assign in_ready  = (state == ST_LOAD) && !start;
  assign accept    = in_valid && in_ready;
  assign depth_hit = (word_cnt == LAST_CNT);
  assign busy      = (state != ST_IDLE);

  // A start pulse only clears session state; a write registered last cycle
  // stays on the port for this cycle and is not cancelled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr_cnt  <= BASE;
      word_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (start) begin
        state     <= ST_LOAD;
        addr_cnt  <= BASE;
        word_cnt  <= '0;
        full      <= 1'b0;
        err       <= 1'b0;
        err_count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_LOAD: begin
            if (accept) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr_cnt;
              mem_wdata <= instr;
              addr_cnt  <= addr_cnt + ADDR_W'(4);
              word_cnt  <= word_cnt + CNT_W'(1);
              if (range_err) begin
                err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              end
              if (depth_hit) full <= 1'b1;
              if (in_last || depth_hit) begin
                state <= ST_FINISH;
                done  <= 1'b1;
              end
            end
          end
          ST_FINISH: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes are queued when a beat
// is accepted and checked by a monitor when the write port fires.
module tb_instr_encoder;
  import riscv_pkg::*;

  localparam int ADDR_W = 12;
  localparam int BASE   = 'h100;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_fmt = '0;
  logic [6:0]        in_opcode = '0;
  logic [4:0]        in_rd = '0;
  logic [2:0]        in_funct3 = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [6:0]        in_funct7 = '0;
  logic [31:0]       in_imm = '0;
  logic              in_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              full;
  logic              err;
  logic [7:0]        err_count;

  instr_encoder #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_funct3 (in_funct3),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .in_last   (in_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .full      (full),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              rt;
    logic [1:0]        fmt;
    logic [31:0]       imm;
    logic [6:0]        opc;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  int                vectors = 0;
  int                miscompares = 0;
  logic [ADDR_W-1:0] exp_addr = ADDR_W'(BASE);

  // Independent model of the core's immediate extender.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] f);
    logic [31:0] r;
    case (f)
      2'b00:   r = {{20{w[31]}}, w[31:20]};
      2'b01:   r = {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: r = {w[31:12], 12'b0};
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write addr=%h data=%h, no write expected", mem_addr, mem_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (mem_addr !== mon_e.addr) begin
          miscompares++;
          $display("[TB] FAIL write_addr got=%h exp=%h", mem_addr, mon_e.addr);
        end
        vectors++;
        if (mon_e.rt) begin
          if (extend(mem_wdata, mon_e.fmt) !== mon_e.imm || mem_wdata[6:0] !== mon_e.opc) begin
            miscompares++;
            $display("[TB] FAIL roundtrip word=%h fmt=%0d ext=%h exp_imm=%h opc=%h exp_opc=%h",
                     mem_wdata, mon_e.fmt, extend(mem_wdata, mon_e.fmt), mon_e.imm,
                     mem_wdata[6:0], mon_e.opc);
          end
        end else if (mem_wdata !== mon_e.data) begin
          miscompares++;
          $display("[TB] FAIL write_data got=%h exp=%h", mem_wdata, mon_e.data);
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    exp_addr = ADDR_W'(BASE);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic last,
                           input logic [31:0] exp_data, input logic rt);
    exp_t e;
    bit accepted = 1'b0;
    in_fmt = fmt; in_opcode = opc; in_rd = rd; in_funct3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_funct7 = 7'($urandom);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.addr = exp_addr; e.data = exp_data; e.rt = rt;
        e.fmt = fmt; e.imm = imm; e.opc = opc;
        sb.push_back(e);
        exp_addr = exp_addr + ADDR_W'(4);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    vectors++;
    if (!accepted) begin
      miscompares++;
      $display("[TB] FAIL beat_accept got=timeout exp=accepted");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({mem_we, mem_addr, mem_wdata, in_ready, busy, done, full, err, err_count} !== 58'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got=%b/%h/%h/%b%b%b%b%b/%0d exp=all zero",
               mem_we, mem_addr, mem_wdata, in_ready, busy, done, full, err, err_count);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle_ignore();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("idle_in_ready", in_ready, 1'b0);
    end
    check_bit("idle_busy", busy, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_addi();
    do_start();
    check_bit("start_busy", busy, 1'b1);
    send_beat(IMM_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b0);
    check_bit("addi_we_latency", mem_we, 1'b1);
    check_bit("addi_done", done, 1'b1);
    @(posedge clk);
    #1;
    check_bit("addi_done_drop", done, 1'b0);
    check_bit("addi_idle", busy, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_start();
    send_beat(IMM_S, OP_STORE, 5'd0, 3'd2, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020A423, 1'b0);
    check_bit("b2b_no_done_first", done, 1'b0);
    send_beat(IMM_B, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, -32'sd4, 1'b1, 32'hFE208EE3, 1'b0);
    check_bit("b2b_done", done, 1'b1);
    check_bit("b2b_ready_drop", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check_bit("b2b_done_drop", done, 1'b0);
  endtask

  task automatic test_lui_err();
    do_start();
    send_beat(IMM_U, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123452B7, 1'b0);
    check_bit("lui_err_clear", err, 1'b0);
    send_beat(IMM_U, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 32'h12345001, 1'b1, 32'h123452B7, 1'b0);
    check_bit("lui_err_set", err, 1'b1);
    check_cnt("lui_err_count", err_count, 8'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_truncation();
    do_start();
    check_cnt("trunc_count_cleared", err_count, 8'd0);
    send_beat(IMM_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h80000093, 1'b0);
    check_cnt("trunc_count_i", err_count, 8'd1);
    send_beat(IMM_B, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 32'd3, 1'b1, 32'h00208163, 1'b0);
    check_cnt("trunc_count_b", err_count, 8'd2);
    @(posedge clk);
    #1;
  endtask

  task automatic test_full();
    do_start();
    for (int i = 1; i <= DEPTH; i++) begin
      send_beat(IMM_I, OP_IMM, 5'(i), 3'd0, 5'd0, 5'd0, 32'(i), 1'b0,
                (32'(i) << 20) | (32'(i) << 7) | 32'h13, 1'b0);
      check_bit("full_flag", full, (i == DEPTH));
      check_bit("full_done", done, (i == DEPTH));
    end
    in_valid = 1'b1;
    check_bit("full_5th_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check_bit("full_5th_ready_idle", in_ready, 1'b0);
    check_bit("full_sticky", full, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_start();
    send_beat(IMM_I, OP_IMM, 5'd3, 3'd0, 5'd0, 5'd0, 32'd7, 1'b0, 32'h00700193, 1'b0);
    check_bit("mid_we_before", mem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_we, mem_addr, mem_wdata, in_ready, busy, done, full, err, err_count} !== 58'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got=%b/%h/%h/%b%b%b%b%b/%0d exp=all zero",
               mem_we, mem_addr, mem_wdata, in_ready, busy, done, full, err, err_count);
    end
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_restart();
    do_start();
    send_beat(IMM_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 32'h1000, 1'b0, 32'h00000093, 1'b0);
    check_cnt("restart_err_before", err_count, 8'd1);
    start = 1'b1;
    exp_addr = ADDR_W'(BASE);
    #1;
    check_bit("restart_ready_low", in_ready, 1'b0);
    check_bit("restart_write_kept", mem_we, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    check_cnt("restart_err_cleared", err_count, 8'd0);
    check_bit("restart_busy", busy, 1'b1);
    send_beat(IMM_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_roundtrip();
    logic [1:0]  f;
    logic [31:0] v;
    logic [31:0] imm;
    logic [6:0]  opc;
    for (int s = 0; s < 3; s++) begin
      do_start();
      for (int b = 0; b < DEPTH; b++) begin
        f = 2'($urandom_range(0, 3));
        v = $urandom;
        case (f)
          2'b00:   begin imm = {{20{v[11]}}, v[11:0]};       opc = OP_IMM;    end
          2'b01:   begin imm = {{20{v[11]}}, v[11:0]};       opc = OP_STORE;  end
          2'b10:   begin imm = {{19{v[12]}}, v[12:1], 1'b0}; opc = OP_BRANCH; end
          default: begin imm = {v[31:12], 12'b0};            opc = OP_LUI;    end
        endcase
        send_beat(f, opc, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                  imm, 1'b0, 32'h0, 1'b1);
      end
      check_bit("rt_no_err", err, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_addi();
    test_back_to_back();
    test_lui_err();
    test_truncation();
    test_full();
    test_reset_mid();
    test_restart();
    test_roundtrip();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL pending_writes got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and loader for the RV32I core. It accepts decoded instruction fields over a valid/ready stream and packs each into a 32-bit instruction word, placing the immediate into its I/S/B/U bit positions. This is the inverse of the core's immediate extender. It then writes the words sequentially into instruction memory through a one-stage registered write port. It serves as the boot/test program loader, so that `extend(encode(x)) == x` holds for every in-range immediate.

## Interface
Parameters:
- `ADDR_W`, default 12: byte-address width of the instruction memory write port.
- `BASE_ADDR`, default 0: byte address of the first word written in a session; must be 4-aligned.
- `DEPTH_WORDS`, default 1024: number of words the session may write; `BASE_ADDR + 4*DEPTH_WORDS <= 2**ADDR_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that opens a load session.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_fmt` in 2: immediate format, using the ImmSrc encoding (00 I, 01 S, 10 B, 11 U).
- `in_opcode` in 7, `in_rd` in 5, `in_funct3` in 3, `in_rs1` in 5, `in_rs2` in 5: instruction fields.
- `in_funct7` in 7: instruction field.
- `in_imm` in 32: sign-extended immediate value, i.e. the value the extender would produce.
- `in_last` in 1: marks the final word of the program.
- `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out 32: instruction memory write port.
- `busy` out 1: high while the state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `full` out 1: sticky; the session reached `DEPTH_WORDS`.
- `err` out 1: sticky; any immediate was out of range.
- `err_count` out 8: number of out-of-range immediates, saturating at 255.

## Operation
- FSM states and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → FINISH on acceptance of a beat with `in_last`, or of the `DEPTH_WORDS`-th beat.
  - FINISH → IDLE unconditionally.
- `start` in IDLE:
  - `mem_addr` counter ← `BASE_ADDR`.
  - Word count ← 0.
  - `full`, `err` and `err_count` are cleared.
- `start` in LOAD or FINISH restarts the session: same clears, state becomes LOAD, and no beat is accepted that cycle.
- `in_ready = (state == LOAD) && !start`. A beat is accepted when `in_valid && in_ready`.
- Packing of the instruction word, by format:
  - I: `{imm[11:0], rs1, funct3, rd, opcode}`.
  - S: `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`.
  - B: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`.
  - U: `{imm[31:12], rd, opcode}`.
  - `funct7` is ignored in all four formats and is reserved for R-type.
- Range checks on the immediate:
  - I and S: `imm[31:11]` all equal.
  - B: `imm[31:12]` all equal, and `imm[0] == 0`.
  - U: `imm[11:0] == 0`.
- On a range violation, the truncated encoding is still written. `err` is set and `err_count` increments, saturating at 255.
- After each write, the address advances by 4. The word count reaches `DEPTH_WORDS` on the final beat; that beat is treated as last and `full` is set. There is no wrap-around.
- `in_valid` while in IDLE or FINISH is ignored; no beat is accepted.

## Timing
- Latency is one cycle: a beat accepted in cycle N appears as `mem_we=1` with `mem_addr`/`mem_wdata` in cycle N+1.
- Throughput is one word per cycle.
- For the last beat accepted in cycle N: cycle N+1 carries its write, `state=FINISH` and `done=1`. Cycle N+2 is IDLE with `done=0`.
- A write already registered still completes in the cycle `start` is high. A restart does not cancel it.
- `err`, `err_count` and `full` update in the same cycle as the corresponding write.
- Reset values: state IDLE, and all of the following are 0: `mem_we`, `mem_addr` (address counter = `BASE_ADDR`), `mem_wdata`, `in_ready`, `busy`, `done`, `full`, `err`, `err_count`.
- Reset is asynchronous: asserting `rst_n` mid-session drops `mem_we` immediately, with no partial write.

## Structure
- Shared package `riscv_pkg` holds:
  - The ImmSrc format enum (IMM_I=2'b00, IMM_S, IMM_B, IMM_U), shared with the extender and the control unit.
  - Opcode constants: OP_IMM 7'b0010011, STORE 7'b0100011, BRANCH 7'b1100011, LUI 7'b0110111.
- Sub-module `imm_encode`: purely combinational. It takes fmt, fields and imm, and produces `instr[31:0]` and `range_err`. The top level holds the FSM, counters and output register.

## Test plan
- `addi x1,x0,5`: I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 → `mem_wdata=0x00500093` at `mem_addr=BASE_ADDR`, one cycle after acceptance.
- `sw x2,8(x1)`, then `beq x1,x2,-4` with `in_last`, back-to-back → words 0x0020A423 at +0 and 0xFE208EE3 at +4. `done` pulses with the second write, and `in_ready` drops the next cycle.
- `lui x5,0x12345`: U, imm=0x12345000 → 0x123452B7. Next, a U beat with imm=0x12345001 → `err=1`, `err_count=1`.
- I with imm=2048, then B with imm=3 → `err_count=2`, and both words are still written with truncated fields.
- `DEPTH_WORDS=4`, 4 beats, no `in_last` → `full=1` and `done` on the 4th write. A 5th beat sees `in_ready=0`.
- `rst_n` low mid-session → all outputs 0 immediately. A `start` mid-session → the next word is written at `BASE_ADDR` and `err_count` is cleared. Round-trip check: feed random in-range imm, require extender output == imm.
